// File: rtl/fetch_stage.sv
// Purpose : RV32I IF stage; holds pcF, drives imem_addr, registers the fetched word into IF/ID.
// Latency : imem_addr = pcF combinationally; IF/ID outputs update one edge after the fetch.
// Backpressure: stallF holds pcF and IF/ID; br_sel (EX redirect) overrides stallF and bubbles IF/ID.
//
// Optional feature macro: FETCH_PERF_EN (adds perf_fetch / perf_redirect counters).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stallF          hazard unit hold request for pcF and IF/ID
//   br_sel,alu_data EX-stage redirect request and target address
//   imem_rdata      combinational instruction word at imem_addr
//   imem_addr       current fetch PC (pcF)
//   pcD,pc4D,instrD,validD  IF/ID pipeline register
//   flushE          clears ID/EX in the redirect cycle
//   perf_fetch, perf_redirect  (FETCH_PERF_EN only) event counters, wrap at 2^32
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        br_sel,
  input  logic [31:0] alu_data,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pcD,
  output logic [31:0] pc4D,
  output logic [31:0] instrD,
  output logic        validD,
  output logic        flushE
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_redirect
`endif
);

  logic [31:0] pc_f;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_f + 32'd4;   // modulo 2^32, wraps FFFF_FFFC -> 0
  assign imem_addr = pc_f;
  // The ID/EX flush must not fire while reset holds the pipeline.
  assign flushE    = br_sel & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f   <= RESET_PC;
      instrD <= NOP_INSTR;
      pcD    <= 32'h0000_0000;
      pc4D   <= 32'h0000_0000;
      validD <= 1'b0;
    end else if (br_sel) begin
      // Redirect wins over stall: the wrong-path word in IF/ID is killed
      // even if decode is stalled. Target is forced word-aligned.
      pc_f   <= {alu_data[31:2], 2'b00};
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (!stallF) begin
      pc_f   <= pc_plus4;
      instrD <= imem_rdata;
      pcD    <= pc_f;
      pc4D   <= pc_plus4;
      validD <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch    <= 32'h0000_0000;
      perf_redirect <= 32'h0000_0000;
    end else if (br_sel) begin
      perf_redirect <= perf_redirect + 32'd1;
    end else if (!stallF) begin
      perf_fetch    <= perf_fetch + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step drives inputs, pushes the expected
// IF/ID + PC state to a scoreboard queue, and compares it after the clock edge.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stallF;
  logic        br_sel;
  logic [31:0] alu_data;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pcD;
  logic [31:0] pc4D;
  logic [31:0] instrD;
  logic        validD;
  logic        flushE;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_redirect;
`endif

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallF        (stallF),
    .br_sel        (br_sel),
    .alu_data      (alu_data),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .pcD           (pcD),
    .pc4D          (pc4D),
    .instrD        (instrD),
    .validD        (validD),
    .flushE        (flushE)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch    (perf_fetch),
    .perf_redirect (perf_redirect)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic [31:0] instr;
    logic        vld;
    logic [31:0] pf;
    logic [31:0] pr;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_pc, m_pcd, m_pc4d, m_instr, m_pf, m_pr;
  logic        m_vld;
  logic        use_const;

  function automatic logic [31:0] rd_of(input logic [31:0] pc);
    return {pc[31:2] ^ 30'h2A5A_5A5A, 2'b11};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic br, input logic [31:0] tgt);
    exp_t e;
    logic [31:0] rd;
    @(negedge clk);
    rd         = use_const ? 32'h0010_0093 : rd_of(m_pc);
    rst        = r;
    stallF     = st;
    br_sel     = br;
    alu_data   = tgt;
    imem_rdata = rd;
    #1;
    chk("flushE", {31'd0, flushE}, {31'd0, br & ~r});
    if (!r) chk("imem_addr_pre", imem_addr, m_pc);
    if (r) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcd = 32'd0; m_pc4d = 32'd0;
      m_vld = 1'b0; m_pf = 32'd0; m_pr = 32'd0;
    end else if (br) begin
      m_pc = {tgt[31:2], 2'b00}; m_instr = NOP_INSTR; m_vld = 1'b0; m_pr = m_pr + 32'd1;
    end else if (!st) begin
      m_instr = rd; m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      m_vld = 1'b1; m_pf = m_pf + 32'd1;
    end
    q.push_back('{pc: m_pc, pcd: m_pcd, pc4d: m_pc4d, instr: m_instr, vld: m_vld, pf: m_pf, pr: m_pr});
    @(posedge clk);
    #1;
    rst = 1'b0;
    e = q.pop_front();
    chk("imem_addr", imem_addr, e.pc);
    chk("pcD", pcD, e.pcd);
    chk("pc4D", pc4D, e.pc4d);
    chk("instrD", instrD, e.instr);
    chk("validD", {31'd0, validD}, {31'd0, e.vld});
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch, e.pf);
    chk("perf_redirect", perf_redirect, e.pr);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stallF = 1'b0; br_sel = 1'b0; alu_data = 32'd0; imem_rdata = 32'd0;
    m_pc = 32'd0; m_pcd = 32'd0; m_pc4d = 32'd0; m_instr = 32'd0;
    m_vld = 1'b0; m_pf = 32'd0; m_pr = 32'd0;
    use_const = 1'b1;

    // reset state
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("reset_addr", imem_addr, RESET_PC);
    chk("reset_validD", {31'd0, validD}, 32'd0);
    chk("reset_instrD", instrD, NOP_INSTR);

    // four sequential fetches, constant instruction word
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("run_addr_10", imem_addr, 32'h10);
    chk("run_pcD_C", pcD, 32'hC);
    chk("run_instr", instrD, 32'h0010_0093);
    use_const = 1'b0;

    // redirect with misaligned target, then first target fetch
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_bubble", instrD, NOP_INSTR);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("redir_pcD", pcD, 32'h100);
    chk("redir_valid", {31'd0, validD}, 32'd1);

    // get to pcF=0x20 with live IF/ID content, stall 3 cycles, release
    step(1'b0, 1'b0, 1'b1, 32'h18);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("stall_addr", imem_addr, 32'h20);
    chk("stall_pcD", pcD, 32'h1C);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("release_addr", imem_addr, 32'h24);

    // stall and redirect together: redirect wins
    step(1'b0, 1'b1, 1'b1, 32'h200);
    chk("stallbr_addr", imem_addr, 32'h200);
    chk("stallbr_valid", {31'd0, validD}, 32'd0);

    // wrap-around at top of address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4D", pc4D, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    // mid-run reset with redirect asserted
    step(1'b1, 1'b0, 1'b1, 32'h400);
    chk("midrst_addr", imem_addr, RESET_PC);
    chk("midrst_valid", {31'd0, validD}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("midrst_pf", perf_fetch, 32'd0);
    chk("midrst_pr", perf_redirect, 32'd0);
`endif
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("post_rst_addr", imem_addr, 32'h14);
`ifdef FETCH_PERF_EN
    chk("post_rst_pf", perf_fetch, 32'd5);
    chk("post_rst_pr", perf_redirect, 32'd0);
`endif

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage RV32I pipeline. Holds the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. Consumes the EX-stage branch decision (br_sel) and target (alu_data) to redirect fetch and flush wrong-path instructions. Obeys the hazard unit's stall request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) inserted on flush/reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
stallF  input  1  hazard unit: hold PC and IF/ID register
br_sel  input  1  EX-stage redirect (taken branch, JAL, JALR)
alu_data  input  32  EX-stage redirect target address
imem_rdata  input  32  instruction word at imem_addr (combinational read)
imem_addr  output  32  current PC (pcF) to instruction memory
pcD  output  32  IF/ID: PC of instruction in decode
pc4D  output  32  IF/ID: pcD + 4 (link value)
instrD  output  32  IF/ID: instruction in decode
validD  output  1  IF/ID: instrD is a real fetched instruction
flushE  output  1  combinational: clear ID/EX register this cycle (= br_sel & ~rst)

Behaviour:
- Reset (rst=1 at posedge): pcF <= RESET_PC; instrD <= NOP_INSTR; pcD <= 0; pc4D <= 0; validD <= 0. Reset wins over br_sel and stallF. flushE forced 0 while rst=1.
- Mid-operation reset: same as above; redirect/stall in that cycle are discarded. First cycle after rst falls: imem_addr = RESET_PC; validD = 1 one edge later (unless flushed/stalled).
- imem_addr = pcF always (no extra latency); imem_rdata sampled in the same cycle.
- Next-PC priority at each posedge (rst=0):
  1. br_sel=1: pcF <= {alu_data[31:2], 2'b00}; IF/ID <= bubble (instrD=NOP_INSTR, validD=0, pcD/pc4D hold).
  2. else stallF=1: pcF and all IF/ID outputs hold.
  3. else: pcF <= pcF + 4; instrD <= imem_rdata; pcD <= pcF; pc4D <= pcF + 4; validD <= 1.
- br_sel and stallF together: redirect wins (wrong-path instruction in IF/ID is killed even when decode stalls).
- Arithmetic: 32-bit unsigned, modulo 2^32; pcF = 32'hFFFF_FFFC increments to 32'h0000_0000, pc4D likewise wraps.
- Target low bits [1:0] always cleared; no misalignment exception generated.
- Redirect penalty: 2 bubbles (IF/ID via this block, ID/EX via flushE); first target instruction reaches IF/ID one edge after the redirect edge.
- No internal state besides pcF, IF/ID register and optional counters; no FSM beyond reset/run.

Optional Feature:
Macro FETCH_PERF_EN. Defined: adds outputs perf_fetch (32) and perf_redirect (32), both reset to 0 by rst. perf_fetch increments on every edge where case 3 (normal advance) occurs; perf_redirect increments on every edge where case 1 occurs; both wrap at 2^32. Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then run 4 cycles, imem_rdata = 32'h0010_0093 constant -> imem_addr 0,4,8,C,10; validD=0 after reset, 1 from second edge; pcD 0,4,8,C; pc4D = pcD+4.
- At pcF=0x10 assert br_sel=1, alu_data=0x0000_0103 for one cycle -> flushE=1 that cycle; next imem_addr=0x100; instrD=0x0000_0013, validD=0; following edge pcD=0x100, validD=1.
- stallF=1 for 3 cycles at pcF=0x20 -> imem_addr stays 0x20, instrD/pcD/validD unchanged; release -> pcF 0x24.
- stallF=1 and br_sel=1 same cycle, alu_data=0x200 -> pcF=0x200, instrD=NOP, validD=0 (redirect wins).
- Redirect to 0xFFFF_FFFC, run 2 cycles -> imem_addr 0xFFFF_FFFC then 0x0; pc4D for pcD=0xFFFF_FFFC is 0x0.
- rst=1 mid-run with br_sel=1 asserted -> pcF=RESET_PC, validD=0, flushE=0; with FETCH_PERF_EN: counters read 0, after 5 free-running cycles perf_fetch=5, perf_redirect=0.
